// File: rtl/pe_ipad_ctl_pkg.sv
// Shared types and ring arithmetic for the PE input-pixel scratchpad controller.
package PECtlCfg;
    localparam int IPadSize = 12;
    localparam int AddrWd   = $clog2(IPadSize);
    localparam int ConfDWd  = 6;
    localparam int TileDWd  = 10;

    typedef enum logic [2:0] {IDLE, INIT, LOOP, POP, OLAP} IPadState;

    typedef struct packed {
        logic [AddrWd-1:0] raddr;
        logic [AddrWd-1:0] waddr;
        logic              read;
        logic              write;
    } IPadAddr;

    // Modulo add by compare-subtract; valid while ptr < size and n <= size.
    function automatic logic [AddrWd-1:0] ring_inc(input logic [AddrWd-1:0]  ptr,
                                                   input logic [ConfDWd-1:0] n,
                                                   input logic [ConfDWd-1:0] size);
        logic [ConfDWd:0] sum;
        sum = {{(ConfDWd+1-AddrWd){1'b0}}, ptr} + {1'b0, n};
        if (sum >= {1'b0, size})
            sum = sum - {1'b0, size};
        return sum[AddrWd-1:0];
    endfunction
endpackage

// File: rtl/pe_ipad_ctl_if.sv
// Config, pixel handshake, stall and IPad access bundle of the IPad controller.
interface pe_ipad_ctl_if;
    import PECtlCfg::*;

    logic               i_start;
    logic [ConfDWd-1:0] i_ipad_size;
    logic [ConfDWd-1:0] i_upix;
    logic               i_pixreuse;
    logic [ConfDWd-1:0] i_pm;
    logic [TileDWd-1:0] i_nwin;
    logic               i_pix_valid;
    logic               o_pix_ready;
    logic               i_rd_stall;
    IPadAddr            o_addr;
    logic               o_win_last;
    logic               o_done;
    logic               o_busy;
    IPadState           o_state;

    modport master (
        output i_start, i_ipad_size, i_upix, i_pixreuse, i_pm, i_nwin, i_pix_valid, i_rd_stall,
        input  o_pix_ready, o_addr, o_win_last, o_done, o_busy, o_state
    );

    modport slave (
        input  i_start, i_ipad_size, i_upix, i_pixreuse, i_pm, i_nwin, i_pix_valid, i_rd_stall,
        output o_pix_ready, o_addr, o_win_last, o_done, o_busy, o_state
    );
endinterface

// File: rtl/pe_ipad_ring_cnt.sv
// Ring pointer that clears to zero or advances by a step, wrapping at the tile's window size.
module pe_ipad_ring_cnt
    import PECtlCfg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [ConfDWd-1:0] step,
    input  logic [ConfDWd-1:0] size,
    output logic [AddrWd-1:0]  ptr
);
    always_ff @(posedge clk) begin
        if (!rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ring_inc(ptr, step, size);
    end
endmodule

// File: rtl/pe_ipad_ctl.sv
// IPad controller: fills the ring, replays each window pm times, then retires and refills slots.
module pe_ipad_ctl
    import PECtlCfg::*;
(
    input  logic         clk,
    input  logic         rst,
    pe_ipad_ctl_if.slave bus
);
    IPadState           state;
    logic [ConfDWd-1:0] size, upix, pm, skip, n_ret;
    logic [ConfDWd-1:0] k, p, acc;
    logic [TileDWd-1:0] nwin, win;
    logic [AddrWd-1:0]  wptr, base;
    logic               done, start_go, pix_ready, accept, write, read, last_k, last_p, eff_reuse;

    assign eff_reuse = bus.i_pixreuse | (bus.i_upix > bus.i_ipad_size);
    assign start_go  = (state == IDLE) & bus.i_start;
    assign pix_ready = (state == INIT) | (state == OLAP);
    assign accept    = bus.i_pix_valid & pix_ready;
    // Leading accepts of an oversized step belong to pixels the window never covers.
    assign write     = accept & ~((state == OLAP) & (acc < skip));
    assign read      = (state == LOOP) & ~bus.i_rd_stall;
    assign last_k    = (k == size - 1'b1);
    assign last_p    = (p == pm - 1'b1);

    assign bus.o_pix_ready = pix_ready;
    assign bus.o_addr      = '{raddr: ring_inc(base, k, size), waddr: wptr, read: read, write: write};
    assign bus.o_win_last  = read & last_k & last_p;
    assign bus.o_done      = done;
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_state     = state;

    pe_ipad_ring_cnt u_wptr (
        .clk(clk), .rst(rst), .clr(start_go), .inc(write),
        .step(ConfDWd'(1)), .size(size), .ptr(wptr)
    );

    pe_ipad_ring_cnt u_base (
        .clk(clk), .rst(rst), .clr(start_go), .inc(state == POP),
        .step(n_ret), .size(size), .ptr(base)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            size  <= '0;
            upix  <= '0;
            pm    <= '0;
            skip  <= '0;
            n_ret <= '0;
            nwin  <= '0;
            k     <= '0;
            p     <= '0;
            acc   <= '0;
            win   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.i_start) begin
                    size  <= bus.i_ipad_size;
                    upix  <= bus.i_upix;
                    pm    <= bus.i_pm;
                    nwin  <= bus.i_nwin;
                    skip  <= (bus.i_upix > bus.i_ipad_size) ? bus.i_upix - bus.i_ipad_size : '0;
                    n_ret <= eff_reuse ? bus.i_ipad_size : bus.i_upix;
                    k     <= '0;
                    p     <= '0;
                    acc   <= '0;
                    win   <= '0;
                    state <= INIT;
                end
                INIT: if (accept) begin
                    if (acc == size - 1'b1) begin
                        acc   <= '0;
                        state <= LOOP;
                    end else begin
                        acc <= acc + 1'b1;
                    end
                end
                LOOP: if (read) begin
                    if (!last_k) begin
                        k <= k + 1'b1;
                    end else begin
                        k <= '0;
                        if (!last_p) begin
                            p <= p + 1'b1;
                        end else begin
                            p <= '0;
                            if (win == nwin - 1'b1) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= POP;
                            end
                        end
                    end
                end
                POP: begin
                    acc   <= '0;
                    state <= OLAP;
                end
                OLAP: if (accept) begin
                    if (acc == upix - 1'b1) begin
                        acc   <= '0;
                        win   <= win + 1'b1;
                        state <= LOOP;
                    end else begin
                        acc <= acc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_ipad_ctl.sv
// Bench for pe_ipad_ctl: directed tile table, corner sequences and randomized tiles vs. a pixel-stream model.
module tb_pe_ipad_ctl;
    import PECtlCfg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_ipad_ctl_if bus();
    pe_ipad_ctl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { bit wr; int addr; } acc_t;
    typedef struct { int addr; bit last; } rd_t;
    typedef struct {
        int size; int upix; bit reuse; int pm; int nwin;
        int n_wr; int n_rd; int last_wa; int last_ra;
    } vec_t;

    acc_t acc_q[$];
    rd_t  rd_q[$];
    int   passed = 0, total = 0;
    int   n_wr, n_rd, last_wa, last_ra;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) $display("FAIL %s: got %0d, want %0d", name, got, exp);
        else passed++;
    endtask

    // Expected access stream from the pixel-level view of the tile.
    task automatic build(input int size, input int upix, input bit reuse, input int pm, input int nwin);
        int  written = 0;
        int  base    = 0;
        int  skip;
        bit  eff;
        acc_q.delete();
        rd_q.delete();
        eff  = reuse || (upix > size);
        skip = (upix > size) ? upix - size : 0;
        for (int j = 0; j < size; j++) begin
            acc_q.push_back('{1'b1, written % size});
            written++;
        end
        for (int w = 0; w < nwin; w++) begin
            for (int p = 0; p < pm; p++)
                for (int k = 0; k < size; k++)
                    rd_q.push_back('{(base + k) % size, (k == size - 1) && (p == pm - 1)});
            if (w < nwin - 1) begin
                base = (base + (eff ? size : upix)) % size;
                for (int j = 0; j < upix; j++) begin
                    if (j < skip) acc_q.push_back('{1'b0, 0});
                    else begin
                        acc_q.push_back('{1'b1, written % size});
                        written++;
                    end
                end
            end
        end
    endtask

    task automatic sample(output bit fin);
        IPadAddr a;
        bit      acc;
        acc_t    e;
        rd_t     r;
        a   = bus.o_addr;
        acc = bus.i_pix_valid && bus.o_pix_ready;
        fin = 1'b0;
        if (a.read && a.write) chk("rw_exclusive", 1, 0);
        if (acc) begin
            if (acc_q.size() == 0) chk("accept_extra", 1, 0);
            else begin
                e = acc_q.pop_front();
                chk("write_flag", int'(a.write), int'(e.wr));
                if (e.wr) chk("waddr", int'(a.waddr), e.addr);
            end
        end else if (a.write) chk("write_no_accept", 1, 0);
        if (a.write) begin n_wr++; last_wa = int'(a.waddr); end
        if (bus.o_win_last && !a.read) chk("win_last_no_read", 1, 0);
        if (a.read) begin
            n_rd++;
            last_ra = int'(a.raddr);
            if (rd_q.size() == 0) chk("read_extra", 1, 0);
            else begin
                r = rd_q.pop_front();
                chk("raddr", int'(a.raddr), r.addr);
                chk("win_last", int'(bus.o_win_last), int'(r.last));
                fin = (rd_q.size() == 0);
            end
        end
    endtask

    // Runs one tile from IDLE; abort_at resets the DUT once that many reads have issued.
    task automatic run_tile(input int size, input int upix, input bit reuse, input int pm, input int nwin,
                            input int vprob, input int sprob, input bit noise,
                            input int stall_at, input int abort_at);
        bit fin, due, st_trig, ended;
        int st_left;
        assert (size >= 1 && size <= IPadSize && upix >= 1 && upix < 64 && pm >= 1 && nwin >= 1)
            else $error("FAIL illegal_cfg size=%0d upix=%0d pm=%0d nwin=%0d", size, upix, pm, nwin);
        build(size, upix, reuse, pm, nwin);
        n_wr = 0; n_rd = 0; last_wa = -1; last_ra = -1;
        due = 0; st_trig = 0; st_left = 0; ended = 0;
        bus.i_ipad_size = ConfDWd'(size);
        bus.i_upix      = ConfDWd'(upix);
        bus.i_pixreuse  = reuse;
        bus.i_pm        = ConfDWd'(pm);
        bus.i_nwin      = TileDWd'(nwin);
        bus.i_pix_valid = 1'b0;
        bus.i_rd_stall  = 1'b0;
        bus.i_start     = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.i_start = 1'b0;
        chk("busy_after_start", int'(bus.o_busy), 1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (abort_at >= 0 && n_rd == abort_at) begin
                rst = 1'b0;
                @(posedge clk); @(negedge clk);
                rst = 1'b1;
                bus.i_pix_valid = 1'b0;
                bus.i_rd_stall  = 1'b0;
                #1;
                chk("abort_state", int'(bus.o_state), int'(IDLE));
                chk("abort_addr", int'(bus.o_addr), 0);
                chk("abort_busy", int'(bus.o_busy), 0);
                chk("abort_ready", int'(bus.o_pix_ready), 0);
                return;
            end
            if (!st_trig && stall_at >= 0 && n_rd == stall_at) begin
                st_trig = 1; st_left = 4;
            end
            bus.i_pix_valid = ($urandom_range(99) < vprob);
            bus.i_rd_stall  = (st_left > 0) ? 1'b1 : ($urandom_range(99) < sprob);
            bus.i_start     = noise && !due && ($urandom_range(9) == 0);
            if (bus.i_start) begin
                bus.i_ipad_size = ConfDWd'($urandom_range(1, 12));
                bus.i_upix      = ConfDWd'($urandom_range(1, 15));
                bus.i_pm        = ConfDWd'($urandom_range(1, 3));
                bus.i_nwin      = TileDWd'($urandom_range(1, 4));
            end
            #1;
            if (due) begin
                chk("done_pulse", int'(bus.o_done), 1);
                chk("idle_after_done", int'(bus.o_busy), 0);
                chk("accepts_left", acc_q.size(), 0);
                ended = 1;
                break;
            end
            if (bus.o_done) chk("done_early", 1, 0);
            if (st_left > 0 && rd_q.size() > 0) begin
                chk("stall_no_read", int'(bus.o_addr.read), 0);
                chk("stall_raddr_hold", int'(bus.o_addr.raddr), rd_q[0].addr);
                st_left--;
            end
            sample(fin);
            if (fin) due = 1;
            @(posedge clk); @(negedge clk);
        end
        bus.i_start = 1'b0;
        if (!ended) chk("tile_timeout", 1, 0);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{3, 1, 1'b0, 2, 3,   5, 18,  1,  1};
        tbl[1] = '{2, 3, 1'b1, 1, 2,   4,  4,  1,  1};
        tbl[2] = '{4, 2, 1'b1, 1, 2,   6,  8,  1,  3};
        tbl[3] = '{5, 5, 1'b0, 3, 2,  10, 30,  4,  4};
        tbl[4] = '{12, 5, 1'b0, 1, 4, 27, 48,  2,  2};
        tbl[5] = '{12, 1, 1'b0, 1, 1, 12, 12, 11, 11};
        tbl[6] = '{1, 1, 1'b0, 2, 2,   2,  4,  0,  0};

        bus.i_start = 0; bus.i_ipad_size = 0; bus.i_upix = 0; bus.i_pixreuse = 0;
        bus.i_pm = 0; bus.i_nwin = 0; bus.i_pix_valid = 0; bus.i_rd_stall = 0;
        rst = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("reset_state", int'(bus.o_state), int'(IDLE));
        chk("reset_addr", int'(bus.o_addr), 0);
        chk("reset_ready", int'(bus.o_pix_ready), 0);
        chk("reset_done", int'(bus.o_done), 0);
        chk("reset_busy", int'(bus.o_busy), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_tile(tbl[i].size, tbl[i].upix, tbl[i].reuse, tbl[i].pm, tbl[i].nwin, 100, 0, 0, -1, -1);
            chk("tbl_writes", n_wr, tbl[i].n_wr);
            chk("tbl_reads", n_rd, tbl[i].n_rd);
            chk("tbl_last_waddr", last_wa, tbl[i].last_wa);
            chk("tbl_last_raddr", last_ra, tbl[i].last_ra);
        end

        // Four-cycle stall in the middle of the second pass of the first window.
        run_tile(3, 1, 0, 2, 3, 100, 0, 0, 4, -1);
        chk("stall_reads", n_rd, 18);
        // Bursty upstream valid during INIT and OLAP.
        run_tile(3, 1, 0, 2, 3, 35, 0, 0, -1, -1);
        chk("gap_writes", n_wr, 5);
        // Reset during the second window, then a clean rerun.
        run_tile(3, 1, 0, 2, 3, 100, 0, 0, -1, 7);
        @(negedge clk);
        run_tile(3, 1, 0, 2, 3, 100, 0, 0, -1, -1);
        chk("rerun_writes", n_wr, 5);
        chk("rerun_reads", n_rd, 18);
        // Start pulses while busy must not disturb a wrapping 12-slot tile.
        run_tile(12, 5, 0, 1, 4, 80, 20, 1, -1, -1);
        chk("wrap_wptr", int'(bus.o_addr.waddr), 3);
        chk("wrap_base", int'(bus.o_addr.raddr), 3);
        chk("wrap_reads", n_rd, 48);

        for (int t = 0; t < 10; t++) begin
            run_tile(int'($urandom_range(1, 12)), int'($urandom_range(1, 15)), 1'($urandom_range(1)),
                     int'($urandom_range(1, 3)), int'($urandom_range(1, 4)),
                     int'($urandom_range(50, 100)), int'($urandom_range(0, 30)), 1, -1, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
